gps_uart_rx: RTL and testbench

GPS_UART_RX -- requirements
Module: gps_uart_rx

---
 rtl/gps_pkg.sv | 21 ++
 rtl/bit_sync.sv | 23 ++
 rtl/gps_uart_rx.sv | 119 +++++++++++
 tb/tb_gps_uart_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// Shared definitions for the GPS serial front end: receiver states and the
// default clock/baud constants also used by gps_interpreter.
package gps_pkg;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Width needed to hold the value cpb-1 (at least one bit).
    function automatic int cnt_width(input int cpb);
        return (cpb > 2) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 1
// so an idle-high line shows no edge coming out of reset.
module bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            // NOTE: non-blocking so q takes the old meta, giving two real stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gps_uart_rx.sv
// 8N1 UART receiver for the GPS module: samples each bit at its centre and
// emits a one-cycle data_valid or framing_error pulse per frame.
module gps_uart_rx
    import gps_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HCPB = CPB / 2;
    localparam int CW   = cnt_width(CPB);

    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HCPB_LAST = CW'(HCPB - 1);

    logic            rx_s;
    rx_state_t       state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shift, shift_n;
    logic            good_stop, bad_stop;

    bit_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            data          <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            shift         <= shift_n;
            data_valid    <= good_stop;
            framing_error <= bad_stop;
            if (good_stop)
                data <= shift;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        good_stop = 1'b0;
        bad_stop  = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s)
                    state_n = START;
            end
            START: begin
                // Half a bit in: still low means a real start bit, else a glitch.
                if (cnt == HCPB_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CPB_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CPB_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n   = IDLE;
                        good_stop = 1'b1;
                    end else begin
                        state_n  = WAIT_HIGH;
                        bad_stop = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                // A line held low (break) must return high before a new start.
                cnt_n = '0;
                if (rx_s)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_gps_uart_rx.sv
// Directed bench for gps_uart_rx at a reduced bit period: good frames,
// back-to-back frames, start glitch, framing error with break, mid-byte reset.
module tb_gps_uart_rx;

    // 1 MHz / 24000 baud -> 41.67 truncated to 41 clocks per bit, half = 20.
    localparam int TB_CLK_FREQ = 1_000_000;
    localparam int TB_BAUD     = 24_000;
    localparam int CPB         = 41;
    localparam int HCPB        = 20;
    // Cycles from the start-bit drive to data_valid: 2 sync + 1 IDLE->START,
    // half a bit, then eight data bits and the stop bit.
    localparam int LAT         = 3 + HCPB + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int overlap_cnt = 0;

    logic [7:0] dv_data[$];
    int         dv_cyc[$];
    int         fe_cyc[$];

    gps_uart_rx #(
        .CLK_FREQ (TB_CLK_FREQ),
        .BAUD     (TB_BAUD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                dv_data.push_back(data);
                dv_cyc.push_back(cyc);
            end
            if (framing_error)
                fe_cyc.push_back(cyc);
            if (data_valid && framing_error)
                overlap_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one full frame starting at the current negedge; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_valid(input string tag, input logic [7:0] exp, input int exp_cyc);
        check({tag, " present"}, 32'(dv_data.size() > 0), 32'd1);
        if (dv_data.size() > 0) begin
            check({tag, " data"}, 32'(dv_data.pop_front()), 32'(exp));
            check({tag, " cycle"}, 32'(dv_cyc.pop_front()), 32'(exp_cyc));
        end
    endtask

    initial begin
        logic [7:0] gprmc[5];
        int         starts[5];
        int         s;
        int         t0;
        logic [7:0] a5;

        gprmc = '{8'h47, 8'h50, 8'h52, 8'h4D, 8'h43};
        a5    = 8'hA5;
        rx    = 1'b1;
        reset = 1'b1;

        repeat (3) @(negedge clk);
        check("reset data", 32'(data), 32'h00);
        check("reset data_valid", 32'(data_valid), 32'd0);
        check("reset framing_error", 32'(framing_error), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle(CPB);

        // Single '$'
        send_frame(8'h24, 1'b1, s);
        idle(CPB);
        expect_valid("dollar", 8'h24, s + LAT);
        check("dollar extra pulses", 32'(dv_data.size()), 32'd0);
        check("dollar framing", 32'(fe_cyc.size()), 32'd0);

        // "GPRMC" with no idle between frames
        for (int i = 0; i < 5; i++)
            send_frame(gprmc[i], 1'b1, starts[i]);
        idle(CPB);
        check("gprmc pulse count", 32'(dv_data.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            expect_valid($sformatf("gprmc[%0d]", i), gprmc[i], starts[i] + LAT);
        check("gprmc framing", 32'(fe_cyc.size()), 32'd0);

        // Short low glitch: rejected at the half-bit sample
        t0 = cyc;
        rx = 1'b0;
        repeat (HCPB / 2) @(negedge clk);
        rx = 1'b1;
        repeat (HCPB + 2 - HCPB / 2) @(negedge clk);
        check("glitch busy before sample", 32'(busy), 32'd1);
        @(negedge clk);
        check("glitch idle at sample", 32'(busy), 32'd0);
        check("glitch elapsed", 32'(cyc - t0), 32'(HCPB + 3));
        idle(CPB);
        check("glitch no data_valid", 32'(dv_data.size()), 32'd0);
        check("glitch no framing", 32'(fe_cyc.size()), 32'd0);

        // Bad stop bit, line held low for three bit times, then 0x41
        send_frame(8'h55, 1'b0, s);
        repeat (3 * CPB) @(negedge clk);
        check("break busy", 32'(busy), 32'd1);
        check("break framing count", 32'(fe_cyc.size()), 32'd1);
        if (fe_cyc.size() > 0)
            check("break framing cycle", 32'(fe_cyc.pop_front()), 32'(s + LAT));
        check("break no data_valid", 32'(dv_data.size()), 32'd0);
        check("break data held", 32'(data), 32'h43);
        idle(CPB);
        check("break released", 32'(busy), 32'd0);
        send_frame(8'h41, 1'b1, s);
        idle(CPB);
        expect_valid("after break", 8'h41, s + LAT);
        check("after break framing", 32'(fe_cyc.size()), 32'd0);

        // Reset pulse in the middle of bit 4 of 0xA5; the sender abandons the frame
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = a5[i];
            repeat (CPB) @(negedge clk);
        end
        rx = a5[4];
        repeat (HCPB) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset data cleared", 32'(data), 32'h00);
        idle(2 * CPB);
        check("midreset no data_valid", 32'(dv_data.size()), 32'd0);
        check("midreset no framing", 32'(fe_cyc.size()), 32'd0);
        send_frame(8'h3C, 1'b1, s);
        idle(CPB);
        expect_valid("after reset", 8'h3C, s + LAT);
        check("after reset extra pulses", 32'(dv_data.size()), 32'd0);

        check("valid/framing overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
